// File: rtl/pipe_pkg.sv
// ============================================================================
// Module   : pipe_pkg
// Purpose  : Field widths, EX/MEM field offsets and control typedef shared by
//            the pipeline boundary registers.
// Revision : 1.0
// ============================================================================
`default_nettype none

package pipe_pkg;

   localparam int PC_W      = 32;
   localparam int ALU_W     = 32;
   localparam int RD_W      = 5;
   localparam int WR_CON_W  = 2;
   localparam int MEM_CON_W = 3;

   localparam int EX_MEM_CTRL_W = WR_CON_W + MEM_CON_W;
   localparam int EX_MEM_DATA_W = PC_W + 1 + ALU_W + ALU_W + RD_W;

   // Datapath packing, LSB first: rd, data2, alu_res, zero, pc_4_off
   localparam int RD_LSB    = 0;
   localparam int DATA2_LSB = RD_LSB + RD_W;
   localparam int ALU_LSB   = DATA2_LSB + ALU_W;
   localparam int ZERO_BIT  = ALU_LSB + ALU_W;
   localparam int PC_LSB    = ZERO_BIT + 1;

   typedef struct packed {
      logic [WR_CON_W-1:0]  wr_con;
      logic [MEM_CON_W-1:0] mem_con;
   } ex_mem_ctrl_t;

endpackage

`default_nettype wire

// File: rtl/pipe_skid_buf.sv
// ============================================================================
// Module   : pipe_skid_buf
// Purpose  : Generic valid/ready register slice with a one-entry skid buffer.
//            The CLR_W most-significant bits are zeroed whenever the slot empties.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipe_skid_buf #(
   parameter int W     = 8,
   parameter int CLR_W = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_vec,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_vec
);

   localparam logic [W-1:0] CLR_MASK = ~({W{1'b1}} >> CLR_W);

   logic         main_valid;
   logic [W-1:0] main_vec;
   logic         skid_valid;
   logic [W-1:0] skid_vec;
   logic         in_xfer;
   logic         out_xfer;

   // Ready comes straight from skid state, never from out_ready
   assign in_ready  = !skid_valid;
   assign in_xfer   = in_valid && in_ready;
   assign out_xfer  = main_valid && out_ready;
   assign out_valid = main_valid;
   assign out_vec   = main_vec;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_valid <= 1'b0;
         main_vec   <= '0;
         skid_valid <= 1'b0;
         skid_vec   <= '0;
      end else if (clear) begin
         main_valid <= 1'b0;
         main_vec   <= main_vec & ~CLR_MASK;
         skid_valid <= 1'b0;
      end else if (!main_valid || out_xfer) begin
         if (skid_valid) begin
            main_valid <= 1'b1;
            main_vec   <= skid_vec;
            skid_valid <= 1'b0;
         end else if (in_xfer) begin
            main_valid <= 1'b1;
            main_vec   <= in_vec;
         end else begin
            main_valid <= 1'b0;
            main_vec   <= main_vec & ~CLR_MASK;
         end
      end else if (in_xfer) begin
         skid_valid <= 1'b1;
         skid_vec   <= in_vec;
      end
   end

endmodule

`default_nettype wire

// File: rtl/ex_mem_stage.sv
// ============================================================================
// Module   : ex_mem_stage
// Purpose  : Parametrised EX/MEM pipeline register with skid buffer, flush and
//            bubble zeroing. Optional stall counter under `STALL_CNT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ex_mem_stage
   import pipe_pkg::*;
#(
   parameter int DATA_W = EX_MEM_DATA_W,
   parameter int CTRL_W = EX_MEM_CTRL_W,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data
`ifdef STALL_CNT_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt
`endif
);

   localparam int VEC_W = CTRL_W + DATA_W;

   if (CNT_W < 1) begin : g_cnt_w_check
      $error("ex_mem_stage: CNT_W must be at least 1");
   end

   logic [VEC_W-1:0] in_vec;
   logic [VEC_W-1:0] out_vec;

   assign in_vec = {in_ctrl, in_data};

   // Control sits in the MSBs so the slice clears it on every bubble
   pipe_skid_buf #(
      .W     (VEC_W),
      .CLR_W (CTRL_W)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .clear     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_vec    (in_vec),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_vec   (out_vec)
   );

   assign out_ctrl = out_vec[VEC_W-1 -: CTRL_W];
   assign out_data = out_vec[DATA_W-1:0];

`ifdef STALL_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end
`endif

endmodule

`default_nettype wire
